// File: rtl/lock_sequencer.sv
// Security-state controller: checks keypad entries against the stored code, opens the lock,
// escalates repeated failures into a timed lockout and runs the change-code flow.
module lock_sequencer #(
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int          MAX_ATTEMPTS   = 3,
  parameter int          UNLOCK_CYCLES  = 1000,
  parameter int          LOCKOUT_CYCLES = 5000,
  localparam int         AW             = $clog2(MAX_ATTEMPTS + 1),
  localparam int         TMAX           = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                           : LOCKOUT_CYCLES,
  localparam int         TW             = $clog2(TMAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   digits,
  input  logic          storageFull,
  input  logic          enter,
  input  logic          newPassword,
  output logic          unlocked,
  output logic          alarm,
  output logic          settingCode,
  output logic          clearEntry,
  output logic          codeUpdated,
  output logic [AW-1:0] attemptsLeft
);

  typedef enum logic [1:0] {
    S_LOCKED,
    S_UNLOCKED,
    S_SET_CODE,
    S_LOCKOUT
  } state_t;

  localparam logic [AW-1:0] ATTEMPTS_FULL = AW'(MAX_ATTEMPTS);
  localparam logic [TW-1:0] T_UNLOCK      = TW'(UNLOCK_CYCLES);
  localparam logic [TW-1:0] T_LOCKOUT     = TW'(LOCKOUT_CYCLES);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   code_q, code_d;
  logic [AW-1:0] attempts_d;
  logic          clear_d, updated_d;
  logic          enter_q, new_pw_q;
  logic          enter_rise, new_pw_rise, expired;

  // Keys are levels; holding one down counts as a single event.
  assign enter_rise  = enter & ~enter_q;
  assign new_pw_rise = newPassword & ~new_pw_q;
  assign expired     = (timer_q == TW'(1));

  // NOTE: every variable written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    timer_d    = (timer_q != '0) ? timer_q - TW'(1) : '0;
    code_d     = code_q;
    attempts_d = attemptsLeft;
    clear_d    = 1'b0;
    updated_d  = 1'b0;

    unique case (state_q)
      S_LOCKED: begin
        if (enter_rise) begin
          clear_d = 1'b1;
          if (storageFull) begin
            if (digits == code_q) begin
              state_d    = S_UNLOCKED;
              attempts_d = ATTEMPTS_FULL;
              timer_d    = T_UNLOCK;
            end else if (attemptsLeft <= AW'(1)) begin
              state_d    = S_LOCKOUT;
              attempts_d = '0;
              timer_d    = T_LOCKOUT;
            end else begin
              attempts_d = attemptsLeft - AW'(1);
            end
          end
        end
      end

      S_UNLOCKED: begin
        // enter outranks newPassword when both rise together.
        if (enter_rise) begin
          state_d = S_LOCKED;
          timer_d = '0;
          clear_d = 1'b1;
        end else if (new_pw_rise) begin
          state_d = S_SET_CODE;
          timer_d = T_UNLOCK;
          clear_d = 1'b1;
        end else if (expired) begin
          state_d = S_LOCKED;
        end
      end

      S_SET_CODE: begin
        if (enter_rise && storageFull) begin
          state_d   = S_UNLOCKED;
          code_d    = digits;
          timer_d   = T_UNLOCK;
          clear_d   = 1'b1;
          updated_d = 1'b1;
        end else begin
          // A partial entry is flushed but must not hold the window open past expiry.
          clear_d = enter_rise;
          if (expired) begin
            state_d = S_LOCKED;
          end
        end
      end

      S_LOCKOUT: begin
        if (expired) begin
          state_d    = S_LOCKED;
          attempts_d = ATTEMPTS_FULL;
        end
      end

      default: begin
        state_d = S_LOCKED;
        timer_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_LOCKED;
      timer_q      <= '0;
      // NOTE: the stored code is a real reset target, not a don't-care memory: a reset
      // mid change-code must fall back to the factory code.
      code_q       <= DEFAULT_CODE;
      attemptsLeft <= ATTEMPTS_FULL;
      enter_q      <= 1'b0;
      new_pw_q     <= 1'b0;
      unlocked     <= 1'b0;
      alarm        <= 1'b0;
      settingCode  <= 1'b0;
      clearEntry   <= 1'b0;
      codeUpdated  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      code_q       <= code_d;
      attemptsLeft <= attempts_d;
      enter_q      <= enter;
      new_pw_q     <= newPassword;
      unlocked     <= (state_d == S_UNLOCKED) || (state_d == S_SET_CODE);
      alarm        <= (state_d == S_LOCKOUT);
      settingCode  <= (state_d == S_SET_CODE);
      clearEntry   <= clear_d;
      codeUpdated  <= updated_d;
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed scenarios plus random key traffic, all checked every
// cycle against a deadline-based behavioural model of the lock.
module tb_lock_sequencer;

  localparam int UC   = 8;
  localparam int LC   = 16;
  localparam int MAXA = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits = '0;
  logic        storageFull = 1'b0;
  logic        enter = 1'b0;
  logic        newPassword = 1'b0;
  logic        unlocked, alarm, settingCode, clearEntry, codeUpdated;
  logic [1:0]  attemptsLeft;

  lock_sequencer #(
    .DEFAULT_CODE  (16'h1234),
    .MAX_ATTEMPTS  (MAXA),
    .UNLOCK_CYCLES (UC),
    .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits      (digits),
    .storageFull (storageFull),
    .enter       (enter),
    .newPassword (newPassword),
    .unlocked    (unlocked),
    .alarm       (alarm),
    .settingCode (settingCode),
    .clearEntry  (clearEntry),
    .codeUpdated (codeUpdated),
    .attemptsLeft(attemptsLeft)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a mode, a stored code, a try count and an absolute expiry edge.
  typedef enum {M_LOCKED, M_OPEN, M_SETTING, M_ALARM} mode_t;
  mode_t       mode;
  int          m_att;
  logic [15:0] m_code;
  bit          m_clear, m_upd, p_en, p_np;
  longint      edge_no = 0;
  longint      deadline = 0;

  task automatic model_reset();
    mode = M_LOCKED; m_att = MAXA; m_code = 16'h1234;
    m_clear = 0; m_upd = 0; p_en = 0; p_np = 0;
  endtask

  task automatic model_step();
    bit er, nr, exp_now;
    er = enter && !p_en;
    nr = newPassword && !p_np;
    p_en = enter;
    p_np = newPassword;
    m_clear = 0;
    m_upd = 0;
    exp_now = (edge_no == deadline);
    case (mode)
      M_LOCKED:
        if (er) begin
          m_clear = 1;
          if (storageFull) begin
            if (digits == m_code) begin
              mode = M_OPEN; m_att = MAXA; deadline = edge_no + UC;
            end else begin
              m_att = m_att - 1;
              if (m_att == 0) begin
                mode = M_ALARM; deadline = edge_no + LC;
              end
            end
          end
        end
      M_OPEN:
        if (er) begin
          mode = M_LOCKED; m_clear = 1;
        end else if (nr) begin
          mode = M_SETTING; m_clear = 1; deadline = edge_no + UC;
        end else if (exp_now) begin
          mode = M_LOCKED;
        end
      M_SETTING:
        if (er && storageFull) begin
          m_code = digits; m_upd = 1; m_clear = 1;
          mode = M_OPEN; deadline = edge_no + UC;
        end else begin
          m_clear = er;
          if (exp_now) mode = M_LOCKED;
        end
      M_ALARM:
        if (exp_now) begin
          mode = M_LOCKED; m_att = MAXA;
        end
    endcase
  endtask

  // Single compare process: every cycle after the edge, DUT outputs vs model.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      edge_no++;
      if (!reset) model_reset();
      else model_step();
      #1;
      check("cycle_outputs",
            32'({unlocked, alarm, settingCode, clearEntry, codeUpdated, attemptsLeft}),
            32'({mode == M_OPEN || mode == M_SETTING, mode == M_ALARM, mode == M_SETTING,
                 m_clear, m_upd, 2'(m_att)}));
    end
  end

  logic       s_unl, s_alarm, s_set, s_clr, s_upd;
  logic [1:0] s_att;

  // One key event: drive for one cycle, snapshot outputs after that edge, then release.
  task automatic press(input logic [15:0] d, input logic f, input logic e, input logic n);
    digits = d; storageFull = f; enter = e; newPassword = n;
    @(negedge clk);
    s_unl = unlocked; s_alarm = alarm; s_set = settingCode;
    s_clr = clearEntry; s_upd = codeUpdated; s_att = attemptsLeft;
    enter = 1'b0; newPassword = 1'b0;
    @(negedge clk);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(2);
    check("reset_outputs", 32'({unlocked, alarm, settingCode, clearEntry, codeUpdated}), 0);
    check("reset_attempts", 32'(attemptsLeft), 3);
    reset = 1'b1;
    cyc(1);

    // 1: correct code opens for exactly UC cycles
    press(16'h1234, 1, 1, 0);
    check("t1_unlocked", 32'(s_unl), 1);
    check("t1_clear_pulse", 32'(s_clr), 1);
    check("t1_clear_gone", 32'(clearEntry), 0);
    check("t1_attempts", 32'(s_att), 3);
    cyc(6);
    check("t1_still_open", 32'(unlocked), 1);
    cyc(1);
    check("t1_relocked", 32'(unlocked), 0);
    check("t1_model_locked", 32'(mode == M_LOCKED), 1);

    // 2: three failures -> lockout; correct code ignored; lockout times out
    press(16'h0000, 1, 1, 0);
    check("t2_att2", 32'(s_att), 2);
    press(16'h0000, 1, 1, 0);
    check("t2_att1", 32'(s_att), 1);
    press(16'h0000, 1, 1, 0);
    check("t2_alarm", 32'(s_alarm), 1);
    check("t2_model_att", 32'(m_att), 0);
    press(16'h1234, 1, 1, 0);
    check("t2_ignored_clear", 32'(s_clr), 0);
    check("t2_ignored_unl", 32'(s_unl), 0);
    cyc(12);
    check("t2_alarm_held", 32'(alarm), 1);
    cyc(1);
    check("t2_alarm_off", 32'(alarm), 0);
    check("t2_att_restored", 32'(attemptsLeft), 3);

    // 3: enter held for 10 cycles is one attempt
    digits = 16'h0000; storageFull = 1'b1; enter = 1'b1;
    cyc(10);
    enter = 1'b0;
    cyc(1);
    check("t3_one_attempt", 32'(attemptsLeft), 2);
    press(16'h1234, 1, 1, 0);
    check("t3_unlock_resets", 32'(s_att), 3);
    press(16'h0000, 0, 1, 0);
    check("t3_manual_relock", 32'(s_unl), 0);

    // 4: change code to 4321
    press(16'h1234, 1, 1, 0);
    press(16'h0000, 0, 0, 1);
    check("t4_setting", 32'(s_set), 1);
    check("t4_np_clear", 32'(s_clr), 1);
    press(16'h4321, 1, 1, 0);
    check("t4_updated", 32'(s_upd), 1);
    check("t4_set_done", 32'({s_unl, s_set}), 2);
    check("t4_updated_gone", 32'(codeUpdated), 0);
    press(16'h0000, 0, 1, 0);
    press(16'h1234, 1, 1, 0);
    check("t4_old_fails", 32'({s_unl, s_att}), 2);
    check("t4_model_code", 32'(m_code), 32'h4321);
    press(16'h4321, 1, 1, 0);
    check("t4_new_opens", 32'({s_unl, s_att}), 7);
    press(16'h0000, 0, 1, 0);

    // 5: partial entry; simultaneous enter+newPassword while open
    press(16'h0000, 0, 1, 0);
    check("t5_partial", 32'({s_clr, s_unl, s_att}), 32'b1011);
    press(16'h4321, 1, 1, 0);
    press(16'h0000, 1, 1, 1);
    check("t5_enter_wins", 32'({s_unl, s_set, s_clr}), 1);

    // 6: async reset mid SET_CODE and mid LOCKOUT
    press(16'h4321, 1, 1, 0);
    press(16'h0000, 0, 0, 1);
    check("t6_in_set", 32'(s_set), 1);
    #2 reset = 1'b0;
    #1 check("t6_rst_set", 32'({unlocked, settingCode, attemptsLeft}), 3);
    @(negedge clk) reset = 1'b1;
    cyc(1);
    press(16'h1234, 1, 1, 0);
    check("t6_default_code", 32'(s_unl), 1);
    press(16'h0000, 0, 1, 0);
    repeat (3) press(16'h0000, 1, 1, 0);
    check("t6_in_lockout", 32'(s_alarm), 1);
    #2 reset = 1'b0;
    #1 check("t6_rst_lockout", 32'({alarm, attemptsLeft}), 3);
    @(negedge clk) reset = 1'b1;
    cyc(1);
    press(16'h1234, 1, 1, 0);
    check("t6_after_reset", 32'(s_unl), 1);
    press(16'h0000, 0, 1, 0);

    // Random traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 499) != 0);
      case ($urandom_range(0, 3))
        0: digits = 16'h1234;
        1: digits = 16'h4321;
        2: digits = m_code;
        default: digits = 16'($urandom);
      endcase
      storageFull = ($urandom_range(0, 9) != 0);
      enter = ($urandom_range(0, 3) == 0);
      newPassword = ($urandom_range(0, 4) == 0);
      @(negedge clk);
    end
    reset = 1'b1; enter = 1'b0; newPassword = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
